// File: rtl/pl_trace_capture.sv
// rtl/pl_trace_capture.sv - pipeline trace buffer capturing pc/inst/eal/mal/wres, drained oldest-first
// Optional build macro PL_TRACE_STALL_FILTER_EN suppresses CAPTURE samples that repeat the last written pc.
module pl_trace_capture #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 64,
  parameter int MAX_CYCLES = 70,
  parameter int WRAP       = 0,
  parameter int CW         = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  input  logic [XLEN-1:0]          pc,
  input  logic [XLEN-1:0]          inst,
  input  logic [XLEN-1:0]          eal,
  input  logic [XLEN-1:0]          mal,
  input  logic [XLEN-1:0]          wres,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [5*XLEN-1:0]        rd_data,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CW-1:0]            cycles,
  output logic                     done,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_CYCLES);

  logic [5*XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [5*XLEN-1:0] sample;
  logic              trig_hit;
  logic              keep;
  logic              wr_en;
  logic              full;
  logic              stop;
  logic              accept;
  logic [CW-1:0]     cycles_nxt;
  logic [AW:0]       count_nxt;

  assign sample   = {pc, inst, eal, mal, wres};
  assign trig_hit = (state == S_ARMED) && (pc == trig_pc);
  assign full     = (count == FULL);

`ifdef PL_TRACE_STALL_FILTER_EN
  logic [XLEN-1:0] prev_pc;
  logic            prev_vld;

  // prev_vld keeps the very first sample of a window from matching the cleared prev_pc
  assign keep = !(prev_vld && (pc == prev_pc));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prev_pc  <= '0;
      prev_vld <= 1'b0;
    end else if (state == S_IDLE && arm) begin
      prev_pc  <= '0;
      prev_vld <= 1'b0;
    end else if (wr_en) begin
      prev_pc  <= pc;
      prev_vld <= 1'b1;
    end
  end
`else
  assign keep = 1'b1;
`endif

  assign wr_en      = trig_hit || ((state == S_CAPTURE) && keep);
  assign cycles_nxt = (cycles == CMAX) ? cycles : cycles + 1'b1;
  assign count_nxt  = (wr_en && !full) ? count + 1'b1 : count;
  assign stop       = ((WRAP == 0) && (count_nxt == FULL)) ||
                      ((MAX_CYCLES != 0) && (cycles_nxt >= LIMIT));
  assign accept     = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_IDLE;
      count    <= '0;
      cycles   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm) begin
            state    <= trig_en ? S_ARMED : S_CAPTURE;
            cycles   <= '0;
            overflow <= 1'b0;
          end
        end
        S_ARMED: begin
          if (trig_hit) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count_nxt;
            cycles <= CW'(1);
            state  <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          cycles <= cycles_nxt;
          if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count_nxt;
            // buffer full in wrap mode: the write lands on the oldest slot, so drop it
            if (full && (WRAP != 0)) begin
              rd_ptr   <= rd_ptr + 1'b1;
              overflow <= 1'b1;
            end
          end
          if (stop) state <= S_DONE;
        end
        default: begin
          if (accept) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
          end
          if ((count == '0) || (accept && (count == (AW+1)'(1)))) state <= S_IDLE;
        end
      endcase
    end
  end

  assign done     = (state == S_DONE);
  assign rd_valid = done && (count != '0);
  assign rd_data  = mem[rd_ptr];

endmodule

// File: tb/tb_pl_trace_capture.sv
// tb/tb_pl_trace_capture.sv - self-checking bench for pl_trace_capture across three configurations
module tb_pl_trace_capture;
  localparam int XL = 32;
  localparam int DW = 5 * XL;

  logic clk = 1'b0;
  logic clr, arm, trig_en, rd_ready;
  logic [XL-1:0] trig_pc, pc, inst, eal, mal, wres;

  always #5 clk = ~clk;

  logic [1:0]    st  [3];
  logic [4:0]    cn  [3];
  logic [15:0]   cy  [3];
  logic          dn  [3];
  logic          ov  [3];
  logic          rv  [3];
  logic [DW-1:0] rdd [3];
  logic [3:0]    cn_0;
  logic [2:0]    cn_1;
  logic [3:0]    cn_2;

  assign cn[0] = {1'b0, cn_0};
  assign cn[1] = {2'b0, cn_1};
  assign cn[2] = {1'b0, cn_2};

  pl_trace_capture #(.XLEN(XL), .DEPTH(8), .MAX_CYCLES(0), .WRAP(0), .CW(16)) u0 (
    .clk(clk), .clr(clr), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .pc(pc), .inst(inst), .eal(eal), .mal(mal), .wres(wres), .rd_ready(rd_ready),
    .rd_valid(rv[0]), .rd_data(rdd[0]), .state(st[0]), .count(cn_0),
    .cycles(cy[0]), .done(dn[0]), .overflow(ov[0]));

  pl_trace_capture #(.XLEN(XL), .DEPTH(4), .MAX_CYCLES(10), .WRAP(1), .CW(16)) u1 (
    .clk(clk), .clr(clr), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .pc(pc), .inst(inst), .eal(eal), .mal(mal), .wres(wres), .rd_ready(rd_ready),
    .rd_valid(rv[1]), .rd_data(rdd[1]), .state(st[1]), .count(cn_1),
    .cycles(cy[1]), .done(dn[1]), .overflow(ov[1]));

  pl_trace_capture #(.XLEN(XL), .DEPTH(8), .MAX_CYCLES(3), .WRAP(0), .CW(16)) u2 (
    .clk(clk), .clr(clr), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .pc(pc), .inst(inst), .eal(eal), .mal(mal), .wres(wres), .rd_ready(rd_ready),
    .rd_valid(rv[2]), .rd_data(rdd[2]), .state(st[2]), .count(cn_2),
    .cycles(cy[2]), .done(dn[2]), .overflow(ov[2]));

  // Reference model: a bounded oldest-first list per instance plus a phase number
  int            mst [3];
  int            msz [3];
  int            mhd [3];
  int            mcy [3];
  bit            movf [3];
  bit            mhp [3];
  logic [XL-1:0] mpp [3];
  logic [DW-1:0] mb  [3][8];

  logic [XL-1:0] dr [3][16];
  int            nd [3];
  bit            hold [3];
  logic [DW-1:0] hd [3];

  int n_chk = 0;
  int n_fail = 0;

  function automatic int mdep(input int k);
    return (k == 1) ? 4 : 8;
  endfunction
  function automatic int mwrap(input int k);
    return (k == 1) ? 1 : 0;
  endfunction
  function automatic int mmax(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 10 : 3);
  endfunction

  task automatic chk(input string nm, input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic mpush(input int k, input logic [DW-1:0] s);
    if (msz[k] < mdep(k)) begin
      mb[k][(mhd[k] + msz[k]) % mdep(k)] = s;
      msz[k]++;
    end else begin
      mb[k][mhd[k]] = s;
      mhd[k] = (mhd[k] + 1) % mdep(k);
      movf[k] = 1'b1;
    end
    mhp[k] = 1'b1;
    mpp[k] = s[DW-1 -: XL];
  endtask

  task automatic model_step();
    logic [DW-1:0] s;
    s = {pc, inst, eal, mal, wres};
    for (int k = 0; k < 3; k++) begin
      case (mst[k])
        0: if (arm) begin
          mst[k] = trig_en ? 1 : 2;
          mcy[k] = 0; movf[k] = 1'b0; mhp[k] = 1'b0;
        end
        1: if (pc == trig_pc) begin
          mpush(k, s); mcy[k] = 1; mst[k] = 2;
        end
        2: begin
`ifdef PL_TRACE_STALL_FILTER_EN
          if (!(mhp[k] && pc == mpp[k])) mpush(k, s);
`else
          mpush(k, s);
`endif
          if (mcy[k] < 65535) mcy[k]++;
          if ((mwrap(k) == 0 && msz[k] == mdep(k)) || (mmax(k) != 0 && mcy[k] >= mmax(k))) mst[k] = 3;
        end
        default: begin
          if (msz[k] != 0 && rd_ready) begin
            mhd[k] = (mhd[k] + 1) % mdep(k);
            msz[k]--;
          end
          if (msz[k] == 0) mst[k] = 0;
        end
      endcase
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk("state", k, DW'(st[k]), DW'(mst[k]));
      chk("count", k, DW'(cn[k]), DW'(msz[k]));
      chk("cycles", k, DW'(cy[k]), DW'(mcy[k]));
      chk("done", k, DW'(dn[k]), DW'(mst[k] == 3));
      chk("overflow", k, DW'(ov[k]), DW'(movf[k]));
      chk("rd_valid", k, DW'(rv[k]), DW'(mst[k] == 3 && msz[k] != 0));
      if (mst[k] == 3 && msz[k] != 0) chk("rd_data", k, rdd[k], mb[k][mhd[k]]);
    end
  endtask

  task automatic cycle();
    for (int k = 0; k < 3; k++) begin
      hold[k] = rv[k] && !rd_ready;
      hd[k]   = rdd[k];
      if (rv[k] && rd_ready && nd[k] < 16) begin
        dr[k][nd[k]] = rdd[k][DW-1 -: XL];
        nd[k]++;
      end
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    for (int k = 0; k < 3; k++)
      if (hold[k]) chk("hold_rd_data", k, rdd[k], hd[k]);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      mst[k] = 0; msz[k] = 0; mhd[k] = 0; mcy[k] = 0;
      movf[k] = 1'b0; mhp[k] = 1'b0; mpp[k] = '0; nd[k] = 0;
    end
    for (int k = 0; k < 3; k++) begin
      chk("clr_state", k, DW'(st[k]), DW'(0));
      chk("clr_count", k, DW'(cn[k]), DW'(0));
      chk("clr_rd_valid", k, DW'(rv[k]), DW'(0));
    end
    #1 clr = 1'b0;
  endtask

  task automatic rand_data();
    inst = $urandom; eal = $urandom; mal = $urandom; wres = $urandom;
  endtask

  typedef struct {
    logic                te;
    logic [XL-1:0]       tp;
    int                  mode;
    logic [2:0][4:0]     cnt;
    logic [2:0]          ovf;
    logic [2:0][XL-1:0]  first;
    logic [2:0][XL-1:0]  last;
  } vec_t;

  vec_t tab [4];

  task automatic run_scn(input int i);
    bit ok;
    do_clr();
    arm = 1'b0; rd_ready = 1'b0; trig_en = tab[i].te; trig_pc = tab[i].tp;
    repeat ($urandom_range(0, 3)) begin
      rand_data(); pc = $urandom; cycle();
    end
    arm = 1'b1; pc = 32'hDEAD_0000; rand_data(); cycle();
    arm = 1'b0; pc = '0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      rand_data(); cycle(); pc += 4;
      if (st[0] == 2'd3 && st[1] == 2'd3 && st[2] == 2'd3) begin ok = 1'b1; break; end
    end
    chk("capture_reaches_done", i, DW'(ok), DW'(1));
    for (int k = 0; k < 3; k++) begin
      chk("done_count", k, DW'(cn[k]), DW'(tab[i].cnt[k]));
      chk("done_overflow", k, DW'(ov[k]), DW'(tab[i].ovf[k]));
    end
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      case (tab[i].mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (c % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      cycle();
      if (st[0] == 2'd0 && st[1] == 2'd0 && st[2] == 2'd0) begin ok = 1'b1; break; end
    end
    rd_ready = 1'b0;
    chk("drain_reaches_idle", i, DW'(ok), DW'(1));
    for (int k = 0; k < 3; k++) begin
      chk("n_drained", k, DW'(nd[k]), DW'(tab[i].cnt[k]));
      chk("first_pc", k, DW'(dr[k][0]), DW'(tab[i].first[k]));
      chk("last_pc", k, DW'((nd[k] > 0) ? dr[k][nd[k]-1] : '1), DW'(tab[i].last[k]));
      for (int j = 1; j < nd[k]; j++)
        chk("pc_step", k, DW'(dr[k][j] - dr[k][j-1]), DW'(4));
    end
  endtask

  initial begin
    clr = 1'b1; arm = 1'b0; trig_en = 1'b0; rd_ready = 1'b0;
    trig_pc = '0; pc = '0; inst = '0; eal = '0; mal = '0; wres = '0;

    // {trig_en, trig_pc, ready mode, count, overflow, first pc, last pc}; packed lists are {u2, u1, u0}
    tab[0] = '{1'b0, 32'h00, 0, {5'd3, 5'd4, 5'd8}, 3'b010,
               {32'h00, 32'h18, 32'h00}, {32'h08, 32'h24, 32'h1C}};
    tab[1] = '{1'b1, 32'h40, 1, {5'd3, 5'd4, 5'd8}, 3'b010,
               {32'h40, 32'h58, 32'h40}, {32'h48, 32'h64, 32'h5C}};
    tab[2] = '{1'b0, 32'h00, 2, {5'd3, 5'd4, 5'd8}, 3'b010,
               {32'h00, 32'h18, 32'h00}, {32'h08, 32'h24, 32'h1C}};
    tab[3] = '{1'b1, 32'h10, 2, {5'd3, 5'd4, 5'd8}, 3'b010,
               {32'h10, 32'h28, 32'h10}, {32'h18, 32'h34, 32'h2C}};

    do_clr();
    check_all();
    for (int i = 0; i < 4; i++) run_scn(i);

    // async clear in the middle of a capture window
    do_clr();
    trig_en = 1'b0; arm = 1'b1; pc = 32'hDEAD_0000; rand_data(); cycle();
    arm = 1'b0; pc = '0;
    for (int c = 0; c < 20; c++) begin
      rand_data(); cycle(); pc += 4;
      if (cn[0] == 5'd5) break;
    end
    chk("pre_clr_count", 0, DW'(cn[0]), DW'(5));
    chk("pre_clr_state", 0, DW'(st[0]), DW'(2));
    do_clr();
    cycle();

`ifdef PL_TRACE_STALL_FILTER_EN
    begin : filt
      logic [XL-1:0] fp [5];
      fp = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h8};
      do_clr();
      trig_en = 1'b0; rd_ready = 1'b0; arm = 1'b1; pc = 32'hDEAD_0000; cycle();
      arm = 1'b0;
      for (int j = 0; j < 5; j++) begin
        pc = fp[j]; rand_data(); cycle();
      end
      chk("filt_count", 0, DW'(cn[0]), DW'(3));
      chk("filt_cycles", 0, DW'(cy[0]), DW'(5));
      pc = 32'hC;
      for (int c = 0; c < 30 && st[0] != 2'd3; c++) begin
        rand_data(); cycle(); pc += 4;
      end
      rd_ready = 1'b1;
      for (int c = 0; c < 40 && st[0] != 2'd0; c++) cycle();
      rd_ready = 1'b0;
      chk("filt_e0", 0, DW'(dr[0][0]), DW'(32'h0));
      chk("filt_e1", 0, DW'(dr[0][1]), DW'(32'h4));
      chk("filt_e2", 0, DW'(dr[0][2]), DW'(32'h8));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
